// File: rtl/add4_pkg.sv
// Shared constants and types for the round-robin adder scheduler.
//   NREQ_DEFAULT / W_DEFAULT / IDW_DEFAULT : default requester count, operand width, index width
//   OPCNT_MAX                              : saturation value of the completed-result counter
//   slot_state_t                           : result slot occupancy state
package add4_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;
    localparam int unsigned W_DEFAULT    = 4;
    localparam int unsigned IDW_DEFAULT  = $clog2(NREQ_DEFAULT);

    localparam logic [7:0] OPCNT_MAX = 8'hFF;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/add4_stage.sv
// Registered W-bit adder with load enable.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture a + b this cycle
//   a, b       : operands
//   sum, carry : registered W-bit sum and carry-out
module add4_stage #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    // Zero-extend both operands so the carry lands in the extra bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            {carry, sum} <= '0;
        end else if (load) begin
            {carry, sum} <= {1'b0, a} + {1'b0, b};
        end
    end

endmodule

// File: rtl/add4_rr_scheduler.sv
// Round-robin scheduler sharing one registered adder between NREQ requesters.
//   clk, reset : clock and synchronous active-high reset
//   req        : per-requester request level
//   op_a, op_b : flattened operands, requester i at [i*W +: W]
//   req_mask   : per-requester eligibility
//   gnt        : one-hot grant pulse (combinational), operands captured this cycle
//   res_valid  : result slot holds a sum; res_ready accepts it
//   res_id     : requester index of the current result
//   res_sum    : zero-extended op_a + op_b
//   op_count   : saturating count of accepted results
module add4_rr_scheduler
    import add4_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned W    = W_DEFAULT,
    parameter int unsigned IDW  = IDW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    input  logic [NREQ-1:0]   req_mask,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [IDW-1:0]    res_id,
    output logic [W:0]        res_sum,
    output logic [7:0]        op_count
);

    slot_state_t     state;
    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] eligible;
    logic [IDW:0]    pick;
    logic [IDW-1:0]  pick_idx;
    logic            issue;
    logic [IDW-1:0]  ptr_next;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic [W-1:0]    stage_sum;
    logic            stage_carry;

    // First eligible index at or after ptr, wrapping; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] elig,
                                             input logic [IDW-1:0]  start);
        logic [IDW:0] r;
        int unsigned  idx;
        r = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(start) + k) % NREQ;
            if (!r[IDW] && elig[IDW'(idx)]) begin
                r = {1'b1, IDW'(idx)};
            end
        end
        return r;
    endfunction

    assign eligible = req & req_mask;
    assign pick     = rr_pick(eligible, ptr);
    assign pick_idx = pick[IDW-1:0];
    assign res_valid = (state == SLOT_FULL);

    // The slot can be refilled in the same cycle it drains.
    assign issue    = !reset && pick[IDW] && (!res_valid || res_ready);
    assign ptr_next = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);

    // Grant pulse and operand select for the winning requester.
    always_comb begin
        gnt   = '0;
        sel_a = '0;
        sel_b = '0;
        if (issue) begin
            gnt[pick_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == pick_idx) begin
                sel_a = op_a[i*W +: W];
                sel_b = op_b[i*W +: W];
            end
        end
    end

    add4_stage #(
        .W (W)
    ) u_stage (
        .clk   (clk),
        .reset (reset),
        .load  (issue),
        .a     (sel_a),
        .b     (sel_b),
        .sum   (stage_sum),
        .carry (stage_carry)
    );

    assign res_sum = {stage_carry, stage_sum};

    // Result slot, arbitration pointer, result tag and completion counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SLOT_EMPTY;
            ptr      <= '0;
            res_id   <= '0;
            op_count <= '0;
        end else begin
            case (state)
                SLOT_EMPTY: if (issue)                   state <= SLOT_FULL;
                SLOT_FULL:  if (res_ready && !issue)     state <= SLOT_EMPTY;
                default:                                 state <= SLOT_EMPTY;
            endcase
            if (issue) begin
                ptr    <= ptr_next;
                res_id <= pick_idx;
            end
            if (res_valid && res_ready && (op_count != OPCNT_MAX)) begin
                op_count <= op_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_add4_rr_scheduler.sv
// Self-checking bench for add4_rr_scheduler: per-scenario tasks check grants
// inline and push expected results; a monitor pops and compares on handshake.
module tb_add4_rr_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a;
    logic [NREQ*W-1:0] op_b;
    logic [NREQ-1:0]   req_mask;
    logic [NREQ-1:0]   gnt;
    logic              res_valid;
    logic              res_ready;
    logic [IDW-1:0]    res_id;
    logic [W:0]        res_sum;
    logic [7:0]        op_count;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W:0]     sum;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    add4_rr_scheduler #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .req_mask  (req_mask),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop and compare the oldest expected result on every accepted handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL result_unexpected: got id=%0d sum=%h, none pending", res_id, res_sum);
            end else begin
                e = sb.pop_front();
                if (res_id !== e.id || res_sum !== e.sum) begin
                    n_fail++;
                    $display("FAIL result: got id=%0d sum=%h, expected id=%0d sum=%h",
                             res_id, res_sum, e.id, e.sum);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        op_a[idx*W +: W] = a;
        op_b[idx*W +: W] = b;
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.id  = IDW'(idx);
        e.sum = 5'(op_a[idx*W +: W]) + 5'(op_b[idx*W +: W]);
        sb.push_back(e);
    endtask

    task automatic test_reset();
        next_cycle();
        req = 4'hF;
        @(negedge clk);
        n_checks++; if (gnt !== 4'h0)      begin n_fail++; $display("FAIL reset_gnt: got %b, expected 0000", gnt); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", res_valid); end
        n_checks++; if (res_id !== 2'd0)    begin n_fail++; $display("FAIL reset_id: got %0d, expected 0", res_id); end
        n_checks++; if (res_sum !== 5'h00)  begin n_fail++; $display("FAIL reset_sum: got %h, expected 00", res_sum); end
        n_checks++; if (op_count !== 8'd0)  begin n_fail++; $display("FAIL reset_count: got %0d, expected 0", op_count); end
        next_cycle();
        reset = 1'b0;
        req   = '0;
    endtask

    task automatic test_single();
        exp_t e;
        set_ops(0, 4'h7, 4'h5);
        req = 4'b0001;
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b, expected 0001", gnt); end
        e.id = 2'd0; e.sum = 5'h0C; sb.push_back(e);
        next_cycle();
        req = '0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b, expected 1", res_valid); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty: got %b, expected 0", res_valid); end
        n_checks++; if (op_count !== 8'd1)  begin n_fail++; $display("FAIL single_count: got %0d, expected 1", op_count); end
        next_cycle();
    endtask

    task automatic test_carry_wrap();
        exp_t e;
        set_ops(3, 4'hF, 4'hF);
        req = 4'b1000;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL carry_gnt: got %b, expected 1000", gnt); end
        e.id = 2'd3; e.sum = 5'h1E; sb.push_back(e);
        next_cycle();
        set_ops(0, 4'h2, 4'h3);
        req = 4'b1111;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wrap_gnt: got %b, expected 0001", gnt); end
        push_exp(0);
        next_cycle();
        req = '0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_checks++; if (op_count !== 8'd3) begin n_fail++; $display("FAIL carry_count: got %0d, expected 3", op_count); end
        next_cycle();
    endtask

    task automatic test_all_four();
        int idx;
        for (int i = 0; i < NREQ; i++) set_ops(i, 4'(i*5 + 3), 4'(15 - i*2));
        req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            idx = (1 + k) % NREQ;
            @(negedge clk);
            n_checks++;
            if (gnt !== 4'(1 << idx)) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b, expected %b", k, gnt, 4'(1 << idx)); end
            if (k > 0) begin
                n_checks++;
                if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %b, expected 1", k, res_valid); end
            end
            push_exp(idx);
            next_cycle();
        end
        req = '0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_checks++; if (op_count !== 8'd11) begin n_fail++; $display("FAIL rr_count: got %0d, expected 11", op_count); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        set_ops(1, 4'h9, 4'h8);
        set_ops(2, 4'h4, 4'h6);
        req = 4'b0110;
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL bp_first_gnt: got %b, expected 0010", gnt); end
        push_exp(1);
        next_cycle();
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if (gnt !== 4'b0000)   begin n_fail++; $display("FAIL bp_gnt[%0d]: got %b, expected 0000", k, gnt); end
            n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b, expected 1", k, res_valid); end
            n_checks++; if (res_id !== 2'd1)    begin n_fail++; $display("FAIL bp_id[%0d]: got %0d, expected 1", k, res_id); end
            n_checks++; if (res_sum !== 5'h11)  begin n_fail++; $display("FAIL bp_sum[%0d]: got %h, expected 11", k, res_sum); end
            next_cycle();
        end
        res_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL bp_release_gnt: got %b, expected 0100", gnt); end
        push_exp(2);
        next_cycle();
        req = '0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_checks++; if (op_count !== 8'd13) begin n_fail++; $display("FAIL bp_count: got %0d, expected 13", op_count); end
        next_cycle();
    endtask

    task automatic test_mask();
        int seq [8] = '{3, 1, 3, 1, 2, 3, 0, 1};
        req      = 4'hF;
        req_mask = 4'b1010;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) req_mask = 4'hF;
            @(negedge clk);
            n_checks++;
            if (gnt !== 4'(1 << seq[k])) begin n_fail++; $display("FAIL mask_gnt[%0d]: got %b, expected %b", k, gnt, 4'(1 << seq[k])); end
            push_exp(seq[k]);
            next_cycle();
        end
        req = '0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_checks++; if (op_count !== 8'd21) begin n_fail++; $display("FAIL mask_count: got %0d, expected 21", op_count); end
        next_cycle();
    endtask

    task automatic test_saturation();
        set_ops(0, 4'hC, 4'h9);
        req = 4'b0001;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            n_checks++;
            if (gnt !== 4'b0001) begin n_fail++; $display("FAIL sat_gnt[%0d]: got %b, expected 0001", k, gnt); end
            push_exp(0);
            next_cycle();
        end
        req = '0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_checks++; if (op_count !== 8'hFF) begin n_fail++; $display("FAIL sat_count: got %0d, expected 255", op_count); end
        next_cycle();
    endtask

    task automatic test_reset_midop();
        set_ops(2, 4'hA, 4'h7);
        req = 4'b0100;
        res_ready = 1'b0;
        @(negedge clk);
        n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL midrst_gnt: got %b, expected 0100", gnt); end
        push_exp(2);
        next_cycle();
        req = 4'b1010;
        res_ready = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_inflight: got %b, expected 1", res_valid); end
        n_checks++; if (gnt !== 4'b0000)    begin n_fail++; $display("FAIL midrst_gnt_in_reset: got %b, expected 0000", gnt); end
        sb.delete();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", res_valid); end
        n_checks++; if (op_count !== 8'd0)  begin n_fail++; $display("FAIL midrst_count: got %0d, expected 0", op_count); end
        n_checks++; if (gnt !== 4'b0010)    begin n_fail++; $display("FAIL midrst_first_gnt: got %b, expected 0010", gnt); end
        push_exp(1);
        next_cycle();
        req = '0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL midrst_post_count: got %0d, expected 1", op_count); end
        next_cycle();
    endtask

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_mask  = 4'hF;
        res_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;

        test_reset();
        test_single();
        test_carry_wrap();
        test_all_four();
        test_backpressure();
        test_mask();
        test_saturation();
        test_reset_midop();

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/add4_rr_scheduler.md
Name: add4_rr_scheduler

Overview:
- Shares one registered 4-bit adder stage between NREQ requesters using round-robin arbitration.
- Each granted requester's operand pair goes into the shared adder. The 5-bit sum returns one cycle later on a valid/ready result port, tagged with the requester index.
- Sits between requesting logic on ui_in/uio_in and the uo_out result path. It replaces direct wiring of the adder to pins.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 4, operand width in bits.
- IDW, 2, requester-index width; must equal clog2(NREQ).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester request level; held high with stable operands until granted.
- op_a  input  NREQ*W  flattened A operands; requester i occupies bits [i*W +: W].
- op_b  input  NREQ*W  flattened B operands, same layout.
- req_mask  input  NREQ  1 = requester eligible; masked requests are ignored, not dropped.
- gnt  output  NREQ  one-hot, single-cycle pulse; operands of the granted requester are captured this cycle.
- res_valid  output  1  result slot holds a valid sum.
- res_ready  input  1  consumer accepts the result when res_valid & res_ready.
- res_id  output  IDW  index of the requester that produced res_sum.
- res_sum  output  W+1  op_a + op_b with carry in MSB.
- op_count  output  8  saturating count of completed (accepted) results.

Behaviour:
- All state updates on posedge clk. reset=1 dominates every other input in the same cycle.
- Reset values: gnt=0, res_valid=0, res_id=0, res_sum=0, op_count=0, RR pointer=0.
- Eligible set: E = req & req_mask.
- Issue condition: issue = (E != 0) & (!res_valid | res_ready).
  - The result slot may be refilled in the same cycle it drains, giving a throughput of 1 op/cycle.
- Arbitration: starting from pointer p, grant the lowest index i >= p (mod NREQ, wrap-around) with E[i]=1.
  - On a grant, p <= (i+1) mod NREQ.
  - Without a grant, p holds.
- gnt is combinational from E, p and the slot state, and is asserted only when issue=1. It is never asserted during reset.
- Latency: a grant in cycle N gives res_valid=1 from cycle N+1.
  - res_sum = zero-extended op_a[i] + op_b[i], W+1 bits, no truncation.
  - res_id = i.
- Result slot FSM has two states:
  - EMPTY: issue moves to FULL.
  - FULL: res_ready & !issue moves to EMPTY; res_ready & issue stays FULL with new data; !res_ready stays FULL with res_sum/res_id stable.
- Backpressure: while FULL & !res_ready, no gnt is asserted, and requests stay pending with the pointer unchanged.
- op_count increments by 1 on each res_valid & res_ready handshake and saturates at 255.
- Masking: a requester masked while its req is high gets no grant, and the pointer skips it. Unmasking makes it eligible the next cycle.
- req dropped before grant: no effect and no error.
- Reset mid-operation: any in-flight result is discarded; res_valid=0 in the cycle after reset.

Decomposition:
- Shared package add4_pkg holds: W and NREQ defaults, IDW, and the OPCNT_MAX=8'hFF constant.
- One sub-module, add4_stage: registered W-bit adder with load enable, producing sum and carry. It is the same datapath previously driven directly from pins.
- Round-robin pick logic stays inline as a function in the scheduler.

Test Plan:
- Single request: req=0001, op_a[0]=4'h7, op_b[0]=4'h5, res_ready=1 -> gnt=0001 in cycle N; cycle N+1 res_valid=1, res_id=0, res_sum=5'h0C; op_count=1 after the handshake.
- Carry and wrap: requester 3 with A=F, B=F -> res_sum=5'h1E, res_id=3; next pointer=0.
- All four requesting continuously, res_ready=1 -> gnt order 0,1,2,3,0,...; one result per cycle; res_ids follow the same order.
- Backpressure: slot FULL, res_ready=0 for 3 cycles with req=0110 -> gnt=0 and res_sum/res_id stable for those cycles; on res_ready=1, the result is accepted and the next grant follows in the same cycle.
- Mask: req=1111, req_mask=1010 -> grants only to 1 and 3, alternating; set mask=1111 -> 0 and 2 join the rotation in the next arbitration cycle.
- Reset mid-op: assert reset in the cycle res_valid=1 with res_ready=0 -> next cycle res_valid=0, op_count=0, pointer=0; first post-reset grant goes to the lowest eligible index.
